// File: rtl/fls_disp.sv
// Four-digit multiplexed seven-segment driver for a 7-bit value with a double-dabble converter.
// Define FLS_DISP_HEX_EN for a hexadecimal display without the converter FSM.
module fls_disp #(
   parameter int SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] val,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       busy
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [6:0]    cur_val;
   logic [11:0]   disp;      // {hundreds, tens, ones}
   logic [CW-1:0] scan_cnt;
   logic [1:0]    slot;
   logic          wrap;
   logic [3:0]    nxt_an;
   logic [6:0]    nxt_seg;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

`ifdef FLS_DISP_HEX_EN

   assign busy = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_val <= '0;
         disp    <= '0;
      end else if (val != cur_val) begin
         cur_val <= val;
         disp    <= {4'd0, 1'b0, val[6:4], val[3:0]};
      end
   end

`else

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_nxt;
   logic [18:0] sh;          // {hundreds, tens, ones, binary}
   logic [6:0]  cap;
   logic [2:0]  step;

   // One double-dabble iteration: correct each BCD nibble, then shift left.
   function automatic logic [18:0] dabble_step(input logic [18:0] s);
      logic [18:0] t;
      // NOTE: blocking assignments here because t is a local temporary inside combinational code.
      t = s;
      for (int i = 0; i < 3; i++) begin
         if (t[7+4*i +: 4] >= 4'd5) t[7+4*i +: 4] = t[7+4*i +: 4] + 4'd3;
      end
      return {t[17:0], 1'b0};
   endfunction

   // NOTE: non-blocking assignments for every clocked register so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (val != cur_val) state_nxt = SHIFT;
         SHIFT:   if (step == 3'd6)   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh      <= '0;
         cap     <= '0;
         step    <= '0;
         cur_val <= '0;
         disp    <= '0;
      end else begin
         case (state)
            IDLE: if (val != cur_val) begin
               sh   <= {12'd0, val};
               cap  <= val;
               step <= '0;
            end
            SHIFT: begin
               sh   <= dabble_step(sh);
               step <= step + 3'd1;
            end
            DONE: begin
               disp    <= sh[18:7];
               cur_val <= cap;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

`endif

   assign wrap = (scan_cnt == CW'(SCAN_DIV - 1));

   // Hundreds is zero in hex mode, so the same blanking rules cover both builds.
   always_comb begin
      nxt_an  = 4'b1111;
      nxt_seg = 7'h7F;
      case (slot)
         2'd0: begin
            nxt_an  = 4'b1110;
            nxt_seg = glyph(disp[3:0]);
         end
         2'd1: if (disp[11:8] != 4'd0 || disp[7:4] != 4'd0) begin
            nxt_an  = 4'b1101;
            nxt_seg = glyph(disp[7:4]);
         end
         2'd2: if (disp[11:8] != 4'd0) begin
            nxt_an  = 4'b1011;
            nxt_seg = glyph(disp[11:8]);
         end
         default: ;
      endcase
   end

   // Each wrap presents the slot the index points at, then moves the index on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         slot     <= '0;
         an       <= 4'b1111;
         seg      <= 7'h7F;
      end else if (wrap) begin
         scan_cnt <= '0;
         slot     <= slot + 2'd1;
         an       <= nxt_an;
         seg      <= nxt_seg;
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

endmodule

// File: doc/fls_disp.md
FLS_DISP -- requirements
Module: fls_disp

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set clk cycles per digit slot (legal range 1..2^20).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 val  input  7  unsigned value from the sequence stage output f, sampled every cycle.
REQ-005 an  output  4  digit enables, active low, bit i = digit i (0 = ones).
REQ-006 seg  output  7  segments {g,f,e,d,c,b,a}, active low.
REQ-007 busy  output  1  high while a conversion is in progress.

Function
REQ-008 Block SHALL hold register cur_val (last converted value) and a 3-digit BCD register disp (hundreds, tens, ones).
REQ-009 Converter FSM SHALL have states IDLE, SHIFT, DONE.
REQ-010 IDLE: on an edge where val != cur_val, SHALL capture val into shift register, clear iteration count, go SHIFT.
REQ-011 SHIFT: SHALL perform one double-dabble step per cycle (add 3 to any BCD nibble >= 5, then shift left 1); after the 7th step SHALL go DONE.
REQ-012 DONE: SHALL load disp with the result and cur_val with the captured value, then go IDLE.
REQ-013 Latency: disp SHALL update exactly 8 edges after the detecting edge; busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-014 val changes during SHIFT/DONE SHALL be ignored; the differing value SHALL be detected in IDLE the cycle after DONE.
REQ-015 Output value range 0..127; hundreds digit SHALL be 0 or 1.
REQ-016 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap, 2-bit slot index SHALL advance 0,1,2,3,0.
REQ-017 an/seg SHALL be registered and updated only at scan-counter wrap, reflecting the new slot index and current disp.
REQ-018 Slot 3 SHALL always be blank (an=4'b1111, seg=7'h7F).
REQ-019 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens both 0; ones never blank.
REQ-020 Lit slot i SHALL drive an with only bit i low and seg with the digit glyph; blank slot SHALL drive an=4'b1111, seg=7'h7F.
REQ-021 Glyphs (active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-022 rst low SHALL immediately force: FSM IDLE, cur_val=0, disp=0, busy=0, scan counter 0, slot index 0, an=4'b1111, seg=7'h7F.
REQ-023 Reset mid-conversion SHALL abandon the conversion with no disp update.
REQ-024 After release, first digit SHALL appear at the first scan wrap (SCAN_DIV edges).

Configuration
REQ-025 Macro FLS_DISP_HEX_EN defined: display SHALL be hexadecimal: ones=val[3:0], tens={0,val[6:4]}, hundreds slot blank; FSM SHALL be omitted; disp/cur_val SHALL update 1 edge after val != cur_val is detected; busy SHALL be tied 0; tens blank when 0.
REQ-026 FLS_DISP_HEX_EN undefined: decimal behaviour of REQ-009..REQ-019 SHALL apply.

Verification (bench SCAN_DIV=4)
REQ-027 rst=0 with val=0 -> an=4'b1111, seg=7'h7F, busy=0; after release, slot 0 shows an=4'b1110, seg=1000000; slots 1..3 blank.
REQ-028 val 0->127 -> busy=1 for 8 cycles starting 1 edge after change; then slots show 7 (an=1110), 2 (an=1101), 1 (an=1011).
REQ-029 val 127->5 after conversion -> ones=0010010, tens and hundreds slots blank (an=4'b1111).
REQ-030 val=100, then 25 two cycles later -> disp shows 1,0,0 after 8 cycles, busy drops 1 cycle, then 2,5 with hundreds blank 8 cycles later.
REQ-031 rst pulsed low during SHIFT of val=99 -> busy=0, an=4'b1111 immediately; after release disp=0, then 99 reconverted.
REQ-032 FLS_DISP_HEX_EN defined, val=7'h5A -> busy stays 0, ones=0001000 (A), tens=0010010 (5), hundreds blank.
